// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - N-floor elevator car controller with SCAN dispatch and internal timers
module elevator_ctrl_n #(
    parameter int FLOORS     = 4,
    parameter int DOOR_TICKS = 64,
    parameter int RUN_TICKS  = 96,
    parameter int CW         = $clog2(((DOOR_TICKS > RUN_TICKS) ? DOOR_TICKS : RUN_TICKS) + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch,
    input  logic [FLOORS-1:0] req,
    input  logic              hold_open,
    input  logic              door_block,
    output logic [FLOORS-1:0] position,
    output logic [FLOORS-1:0] pending,
    output logic [1:0]        ud_mode,
    output logic [1:0]        state,
    output logic              opendoor,
    output logic              mv2nxt
);
    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_IDLE = 2'b01,
        S_MOVE = 2'b10,
        S_DOOR = 2'b11
    } state_t;

    localparam logic [1:0]    UD_NONE   = 2'b00;
    localparam logic [1:0]    UD_UP     = 2'b01;
    localparam logic [1:0]    UD_DOWN   = 2'b10;
    localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_TICKS - 1);
    localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);

    state_t            st;
    logic [CW-1:0]     timer;
    logic [FLOORS-1:0] merged;
    logic              above;
    logic              below;
    logic              at_floor;
    logic              floor_hit;

    assign state = st;

    // Request summaries relative to the car: anything above, below, at this floor, or a new hit here
    always_comb begin
        merged    = pending | req;
        above     = |(pending & ~(((position << 1) - FLOORS'(1)) | position));
        below     = |(pending & (position - FLOORS'(1)));
        at_floor  = |(pending & position);
        floor_hit = |(req & position);
    end

    // Car FSM: dispatch decision, travel and door timing, request latch and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= S_OFF;
            position <= FLOORS'(1);
            pending  <= '0;
            ud_mode  <= UD_NONE;
            opendoor <= 1'b0;
            mv2nxt   <= 1'b0;
            timer    <= '0;
        end else if (!switch) begin
            st       <= S_OFF;
            pending  <= '0;
            ud_mode  <= UD_NONE;
            opendoor <= 1'b0;
            mv2nxt   <= 1'b0;
            timer    <= '0;
        end else begin
            case (st)
                S_OFF: begin
                    st <= S_IDLE;
                end
                S_IDLE: begin
                    pending <= merged;
                    timer   <= '0;
                    if (at_floor) begin
                        st       <= S_DOOR;
                        opendoor <= 1'b1;
                        pending  <= merged & ~position;
                    end else if ((ud_mode == UD_UP) && above) begin
                        st     <= S_MOVE;
                        mv2nxt <= 1'b1;
                    end else if ((ud_mode == UD_DOWN) && below) begin
                        st     <= S_MOVE;
                        mv2nxt <= 1'b1;
                    end else if (above) begin
                        ud_mode <= UD_UP;
                        st      <= S_MOVE;
                        mv2nxt  <= 1'b1;
                    end else if (below) begin
                        ud_mode <= UD_DOWN;
                        st      <= S_MOVE;
                        mv2nxt  <= 1'b1;
                    end else begin
                        ud_mode <= UD_NONE;
                    end
                end
                S_MOVE: begin
                    pending <= merged;
                    if (timer == RUN_LAST) begin
                        timer  <= '0;
                        st     <= S_IDLE;
                        mv2nxt <= 1'b0;
                        // A shift off either end of the shaft is refused and the direction dropped
                        if (ud_mode == UD_UP) begin
                            if (position[FLOORS-1]) begin
                                ud_mode <= UD_NONE;
                            end else begin
                                position <= position << 1;
                            end
                        end else if (ud_mode == UD_DOWN) begin
                            if (position[0]) begin
                                ud_mode <= UD_NONE;
                            end else begin
                                position <= position >> 1;
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DOOR: begin
                    pending <= floor_hit ? (merged & ~position) : merged;
                    if (hold_open || door_block || floor_hit) begin
                        timer <= '0;
                    end else if (timer == DOOR_LAST) begin
                        timer    <= '0;
                        st       <= S_IDLE;
                        opendoor <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    st <= S_OFF;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb/tb_elevator_ctrl_n.sv - self-checking bench for elevator_ctrl_n against a floor-level model
module tb_elevator_ctrl_n;
    localparam int DT = 4;
    localparam int RT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       in_sw[2];
    logic [7:0] in_req[2];
    logic       in_hold[2];
    logic       in_blk[2];

    logic [3:0] pos4, pend4;
    logic [1:0] ud4, st4;
    logic       od4, mv4;
    logic [7:0] pos8, pend8;
    logic [1:0] ud8, st8;
    logic       od8, mv8;

    logic [7:0] a_pos[2];
    logic [7:0] a_pend[2];
    logic [1:0] a_ud[2];
    logic [1:0] a_st[2];
    logic       a_od[2];
    logic       a_mv[2];

    assign a_pos[0]  = {4'h0, pos4};
    assign a_pend[0] = {4'h0, pend4};
    assign a_ud[0]   = ud4;
    assign a_st[0]   = st4;
    assign a_od[0]   = od4;
    assign a_mv[0]   = mv4;
    assign a_pos[1]  = pos8;
    assign a_pend[1] = pend8;
    assign a_ud[1]   = ud8;
    assign a_st[1]   = st8;
    assign a_od[1]   = od8;
    assign a_mv[1]   = mv8;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Floor-level model: state code, floor index, direction (-1/0/+1), cycles left in phase, requests
    int         m_st[2];
    int         m_floor[2];
    int         m_dir[2];
    int         m_left[2];
    logic [7:0] m_pend[2];

    int exp_s1_st[14]  = '{2, 2, 2, 1, 2, 2, 2, 1, 3, 3, 3, 3, 1, 1};
    int exp_s1_pos[14] = '{1, 1, 1, 2, 2, 2, 2, 4, 4, 4, 4, 4, 4, 4};

    int         door_log[$];
    int         door_ud[$];
    logic [1:0] prev_st0;
    int         cnt;
    int         phases;
    bit         got;
    bit         mv_seen;
    logic       prev_mv;

    always #5 clk = ~clk;

    elevator_ctrl_n #(.FLOORS(4), .DOOR_TICKS(DT), .RUN_TICKS(RT)) dut4 (
        .clk(clk), .rst(rst), .switch(in_sw[0]), .req(in_req[0][3:0]),
        .hold_open(in_hold[0]), .door_block(in_blk[0]),
        .position(pos4), .pending(pend4), .ud_mode(ud4), .state(st4),
        .opendoor(od4), .mv2nxt(mv4)
    );

    elevator_ctrl_n #(.FLOORS(8), .DOOR_TICKS(DT), .RUN_TICKS(RT)) dut8 (
        .clk(clk), .rst(rst), .switch(in_sw[1]), .req(in_req[1]),
        .hold_open(in_hold[1]), .door_block(in_blk[1]),
        .position(pos8), .pending(pend8), .ud_mode(ud8), .state(st8),
        .opendoor(od8), .mv2nxt(mv8)
    );

    function automatic int nfl(input int i);
        return (i == 0) ? 4 : 8;
    endfunction

    function automatic logic [1:0] ud_of(input int d);
        return (d == 1) ? 2'b01 : ((d == -1) ? 2'b10 : 2'b00);
    endfunction

    function automatic int idx_of(input logic [7:0] p);
        int r;
        r = -1;
        for (int b = 7; b >= 0; b--) if (p[b]) r = b;
        return r;
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_st[i] = 0; m_floor[i] = 0; m_dir[i] = 0; m_left[i] = 0; m_pend[i] = '0;
    endtask

    task automatic model_step(input int i);
        logic [7:0] r;
        bit up, dn;
        int nxt;
        r = in_req[i] & ((i == 0) ? 8'h0F : 8'hFF);
        if (!in_sw[i]) begin
            m_st[i] = 0; m_pend[i] = '0; m_dir[i] = 0; m_left[i] = 0;
            return;
        end
        case (m_st[i])
            0: m_st[i] = 1;
            1: begin
                up = 1'b0; dn = 1'b0;
                for (int f = 0; f < 8; f++) begin
                    if (m_pend[i][f] && f > m_floor[i]) up = 1'b1;
                    if (m_pend[i][f] && f < m_floor[i]) dn = 1'b1;
                end
                if (m_pend[i][m_floor[i]]) begin
                    m_pend[i] = m_pend[i] | r;
                    m_pend[i][m_floor[i]] = 1'b0;
                    m_st[i] = 3;
                    m_left[i] = DT;
                end else begin
                    m_pend[i] = m_pend[i] | r;
                    if (!((m_dir[i] == 1 && up) || (m_dir[i] == -1 && dn)))
                        m_dir[i] = up ? 1 : (dn ? -1 : 0);
                    if (m_dir[i] != 0) begin
                        m_st[i] = 2;
                        m_left[i] = RT;
                    end
                end
            end
            2: begin
                m_pend[i] = m_pend[i] | r;
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_st[i] = 1;
                    nxt = m_floor[i] + m_dir[i];
                    if (nxt >= 0 && nxt < nfl(i)) m_floor[i] = nxt;
                    else m_dir[i] = 0;
                end
            end
            default: begin
                m_pend[i] = m_pend[i] | r;
                if (r[m_floor[i]]) begin
                    m_pend[i][m_floor[i]] = 1'b0;
                    m_left[i] = DT;
                end else if (in_hold[i] || in_blk[i]) begin
                    m_left[i] = DT;
                end else begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) m_st[i] = 1;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            check("position", i, a_pos[i], 8'(1) << m_floor[i]);
            check("pending", i, a_pend[i], m_pend[i]);
            check("ud_mode", i, a_ud[i], ud_of(m_dir[i]));
            check("state", i, a_st[i], m_st[i]);
            check("opendoor", i, a_od[i], (m_st[i] == 3) ? 1 : 0);
            check("mv2nxt", i, a_mv[i], (m_st[i] == 2) ? 1 : 0);
        end
    endtask

    // One cycle: compare mid-cycle, then advance the model on the edge the DUT uses
    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else model_step(i);
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            if (a_st[0] == 2'b11 && prev_st0 != 2'b11) begin
                door_log.push_back(idx_of(a_pos[0]));
                door_ud.push_back(int'(a_ud[0]));
            end
            prev_st0 = a_st[0];
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_sw[i] = 1'b0; in_req[i] = '0; in_hold[i] = 1'b0; in_blk[i] = 1'b0;
            model_reset(i);
        end
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick();
        tick();
        check("rst_position", 0, a_pos[0], 8'h01);
        check("rst_state", 0, a_st[0], 2'b00);
        check("rst_pending", 0, a_pend[0], 8'h00);
        check("rst_ud", 0, a_ud[0], 2'b00);
        check("rst_opendoor", 0, a_od[0], 1'b0);
        rst = 1'b0;

        // Scenario 1: single request two floors up
        in_sw[0] = 1'b1;
        tick();
        check("s1_idle", 0, a_st[0], 2'b01);
        in_req[0] = 8'h04;
        tick();
        in_req[0] = 8'h00;
        check("s1_latched", 0, a_pend[0], 8'h04);
        for (int k = 0; k < 14; k++) begin
            tick();
            check("s1_state", k, a_st[0], exp_s1_st[k]);
            check("s1_pos", k, a_pos[0], exp_s1_pos[k]);
            if (a_st[0] == 2'b11) check("s1_door_pending", k, a_pend[0], 8'h00);
        end
        check("s1_final_ud", 0, a_ud[0], 2'b00);

        // Scenario 2: SCAN keeps going up before reversing
        prev_st0 = a_st[0];
        in_req[0] = 8'h01; run(1); in_req[0] = 8'h00;
        run(30);
        door_log.delete(); door_ud.delete();
        in_req[0] = 8'h04; run(1); in_req[0] = 8'h00;
        run(1);
        check("s2_moving", 0, a_st[0], 2'b10);
        in_req[0] = 8'h09; run(1); in_req[0] = 8'h00;
        run(60);
        check("s2_door_count", 0, door_log.size(), 3);
        if (door_log.size() == 3) begin
            check("s2_door0_floor", 0, door_log[0], 2);
            check("s2_door1_floor", 0, door_log[1], 3);
            check("s2_door2_floor", 0, door_log[2], 0);
            check("s2_door0_ud", 0, door_ud[0], 1);
            check("s2_door2_ud", 0, door_ud[2], 2);
        end
        check("s2_final_pos", 0, a_pos[0], 8'h01);

        // Scenario 3: hold_open extends the door
        in_req[0] = 8'h01; tick(); in_req[0] = 8'h00;
        tick();
        check("s3_door", 0, a_st[0], 2'b11);
        cnt = a_od[0] ? 1 : 0;
        in_hold[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_od[0]) cnt++;
        end
        in_hold[0] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!a_od[0]) break;
            cnt++;
        end
        check("s3_open_cycles", 0, cnt, 14);
        check("s3_idle_after", 0, a_st[0], 2'b01);

        // Scenario 4: same-floor request in IDLE and in DOOR
        mv_seen = 1'b0;
        in_req[0] = 8'h01; tick(); in_req[0] = 8'h00;
        mv_seen |= a_mv[0];
        tick();
        mv_seen |= a_mv[0];
        check("s4_door", 0, a_st[0], 2'b11);
        cnt = 1;
        tick(); cnt++;
        tick(); cnt++;
        in_req[0] = 8'h01; tick(); cnt++; in_req[0] = 8'h00;
        check("s4_pending_clear", 0, a_pend[0], 8'h00);
        for (int k = 0; k < 20; k++) begin
            tick();
            mv_seen |= a_mv[0];
            if (!a_od[0]) break;
            cnt++;
        end
        check("s4_door_cycles", 0, cnt, 7);
        check("s4_no_move", 0, mv_seen, 1'b0);

        // Scenario 5: switch off mid-travel
        in_req[0] = 8'h02; tick(); in_req[0] = 8'h00;
        for (int k = 0; k < 20; k++) tick();
        in_req[0] = 8'h04; tick(); in_req[0] = 8'h00;
        tick();
        check("s5_moving", 0, a_st[0], 2'b10);
        in_req[0] = 8'h08; tick(); in_req[0] = 8'h00;
        in_sw[0] = 1'b0;
        tick();
        check("s5_off_state", 0, a_st[0], 2'b00);
        check("s5_off_pos", 0, a_pos[0], 8'h02);
        check("s5_off_pending", 0, a_pend[0], 8'h00);
        check("s5_off_mv", 0, a_mv[0], 1'b0);
        in_sw[0] = 1'b1;
        tick();
        check("s5_on_idle", 0, a_st[0], 2'b01);
        for (int k = 0; k < 5; k++) tick();
        check("s5_stays_idle", 0, a_st[0], 2'b01);
        check("s5_stays_pos", 0, a_pos[0], 8'h02);

        // Randomized traffic on both cars
        in_sw[1] = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                in_req[i]  = ($urandom_range(0, 5) == 0) ? (8'($urandom) & ((i == 0) ? 8'h0F : 8'hFF)) : 8'h00;
                in_hold[i] = ($urandom_range(0, 15) == 0);
                in_blk[i]  = ($urandom_range(0, 19) == 0);
                in_sw[i]   = ($urandom_range(0, 299) != 0);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            in_req[i] = '0; in_hold[i] = 1'b0; in_blk[i] = 1'b0; in_sw[i] = 1'b1;
        end

        // Scenario 6: asynchronous reset during DOOR at floor 2
        in_sw[0] = 1'b0; tick(); in_sw[0] = 1'b1; tick();
        in_req[0] = 8'h04; tick(); in_req[0] = 8'h00;
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            tick();
            if (a_st[0] == 2'b11 && a_pos[0] == 8'h04) got = 1'b1;
        end
        check("s6_reach_door", 0, got, 1'b1);
        #2 rst = 1'b1;
        for (int i = 0; i < 2; i++) model_reset(i);
        #1;
        check("s6_async_pos", 0, a_pos[0], 8'h01);
        check("s6_async_state", 0, a_st[0], 2'b00);
        check("s6_async_opendoor", 0, a_od[0], 1'b0);
        tick();
        rst = 1'b0;

        // Eight-floor car: ground to top floor
        in_sw[0] = 1'b0;
        in_sw[1] = 1'b1;
        tick();
        in_req[1] = 8'h80; tick(); in_req[1] = 8'h00;
        phases = 0; prev_mv = 1'b0; got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            tick();
            if (a_mv[1] && !prev_mv) phases++;
            prev_mv = a_mv[1];
            if (a_st[1] == 2'b11) got = 1'b1;
        end
        check("s7_reach_door", 1, got, 1'b1);
        check("s7_move_phases", 1, phases, 7);
        check("s7_pos", 1, a_pos[1], 8'h80);
        check("s7_pending", 1, a_pend[1], 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/elevator_ctrl_n.md
Name: elevator_ctrl_n

Overview:
Parametrised N-floor elevator car controller, successor to the fixed 4-floor state controller.
- Latches floor requests internally.
- Runs a SCAN (continue-in-direction) dispatch policy.
- Owns its door and travel timers; no external end-of-run or end-of-open strobes.
- Sits between the request/button front end and the floor display/door drivers.

Parameters:
FLOORS, 4, number of floors (>=2); position and request vectors are FLOORS bits, bit 0 = ground.
DOOR_TICKS, 64, clk cycles the door stays open after the last (re)start.
RUN_TICKS, 96, clk cycles to travel one floor.
CW, $clog2(max(DOOR_TICKS,RUN_TICKS)+1), timer width (derived; do not override).

Ports:
clk  input  1  system clock (32 Hz tick domain).
rst  input  1  asynchronous, active-high reset.
switch  input  1  master enable; 0 = controller off.
req  input  FLOORS  floor request pulses or levels; OR-ed into the pending register.
hold_open  input  1  door-open button; restarts the door timer while high in DOOR.
door_block  input  1  obstruction sensor; same effect as hold_open.
position  output  FLOORS  one-hot current floor.
pending  output  FLOORS  latched outstanding requests.
ud_mode  output  2  00 none, 01 up, 10 down.
state  output  2  00 OFF, 01 IDLE, 10 MOVE, 11 DOOR.
opendoor  output  1  high exactly while state==DOOR.
mv2nxt  output  1  high exactly while state==MOVE.

Behaviour:
Reset and enable:
- rst (async) forces: state=OFF, position=1 (floor 0), pending=0, ud_mode=00, opendoor=0, mv2nxt=0, timers=0.
- switch=0, synchronous, highest priority after rst: next state OFF, pending cleared, ud_mode=00, opendoor/mv2nxt=0, timers=0, position retained.
- switch=0 mid-MOVE abandons travel; position does not change.
- OFF -> IDLE on the first clk with switch=1. req is ignored while in OFF.

Request latch (switch=1, state!=OFF):
- pending_next = (pending | req) & ~clr.
- clr = position on the cycle the FSM enters DOOR.
- clr = position on every DOOR cycle where req hits the current floor; that hit also restarts the door timer.

Derived signals:
- above = |(pending & ~(((position<<1)-1)|position))
- below = |(pending & (position-1))

IDLE (one-cycle decision), in priority order:
1. pending & position != 0 -> DOOR, door timer=0.
2. ud_mode==01 & above -> MOVE up.
3. ud_mode==10 & below -> MOVE down.
4. above -> ud_mode=01, MOVE up.
5. below -> ud_mode=10, MOVE down.
6. Otherwise ud_mode=00, stay IDLE.

MOVE:
- Run timer counts 0..RUN_TICKS-1; MOVE lasts exactly RUN_TICKS cycles.
- On the final cycle: position shifts by one (<<1 for up, >>1 for down), timer clears, state -> IDLE.
- Shifts saturate: never shift past bit FLOORS-1 or bit 0. A blocked shift leaves position unchanged and ud_mode=00.
- Requests arriving during MOVE are latched. Travel direction is not re-evaluated until IDLE.

DOOR:
- Door timer counts to DOOR_TICKS-1, then state -> IDLE and opendoor drops.
- hold_open, door_block, or a same-floor req forces timer=0 that cycle, extending the door indefinitely while asserted.
- ud_mode is held during DOOR so SCAN continues afterwards.

Timing:
- Request at an adjacent floor while IDLE at floor k: MOVE starts next cycle; door opens 1+RUN_TICKS+1 cycles after IDLE decides.

Invariants:
- position is always one-hot.
- opendoor and mv2nxt are never high together.

Test Plan:
(FLOORS=4, DOOR_TICKS=4, RUN_TICKS=3 throughout.)
1. Reset, switch=1, req=0100 one cycle -> OFF, IDLE, then MOVE ×3 to position 0010, IDLE, MOVE ×3 to 0100, IDLE, DOOR ×4 with opendoor=1 and pending=0000, then IDLE with ud_mode=00.
2. Car at 0010 moving up, req=0001 and req=1000 both pending -> serves 1000 first (SCAN), then reverses with ud_mode=10 to 0001.
3. In DOOR at 0001, hold_open high 10 cycles -> opendoor stays 1 for 10+4 cycles, then IDLE.
4. Request for the current floor while in IDLE -> DOOR next cycle, mv2nxt never asserts. Same-floor req during DOOR -> timer restarts and the pending bit stays 0.
5. switch=0 during MOVE from 0010 up -> next cycle OFF, position=0010, pending=0. switch=1 again -> IDLE, no motion.
6. rst asserted asynchronously mid-DOOR at 0100 -> outputs immediately position=0001, state=00, opendoor=0. FLOORS=8 rerun of scenario 1 with req=10000000 -> 7 MOVE phases, then DOOR.
